lut_gate_pipe: RTL and testbench

- Parametrised successor to the single-bit mux-built gate: a WIDTH-bit bitwise 2-input logic unit.
- Each output bit is a 4:1 mux tree that selects from a runtime-programmable 4-entry truth table (LUT).
- The LUT is loaded serially. Operands move through a one-deep registered output stage with valid/ready handshakes.
- Used as a reconfigurable gate in combinational-logic exercises and as a drop-in AND/OR/XOR datapath element.

---
 rtl/lut_gate_pipe.sv | 130 +++++++++++++
 tb/tb_lut_gate_pipe.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_gate_pipe.sv
// Reconfigurable WIDTH-bit two-input logic unit: a serially loaded 4-entry truth
// table applied bitwise, with a one-deep valid/ready registered output stage.
module lut_gate_pipe #(
    parameter int unsigned WIDTH       = 8,
    parameter logic [3:0]  DEFAULT_LUT = 4'b1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic             cfg_bit,
    output logic             cfg_busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic [3:0]       lut,
    output logic [15:0]      xfer_count
);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t           state_q, state_d;
    logic [2:0]       shadow_q, shadow_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [3:0]       lut_q, lut_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             out_valid_q, out_valid_d;
    logic [15:0]      xfer_q, xfer_d;
    logic             accept;
    logic             xfer;

    // Each result bit is a 4:1 mux over the truth table, selected by {a[i], b[i]}.
    function automatic logic [WIDTH-1:0] lut_apply(input logic [3:0] tt,
                                                   input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = tt[{x[i], y[i]}];
        end
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        lut_d    = lut_q;
        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    shadow_d[0] = cfg_bit;
                    cnt_d       = 2'd1;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                if (cfg_valid) begin
                    case (cnt_q)
                        2'd3: begin
                            lut_d   = {cfg_bit, shadow_q};
                            cnt_d   = 2'd0;
                            state_d = IDLE;
                        end
                        2'd2: begin
                            shadow_d[2] = cfg_bit;
                            cnt_d       = 2'd3;
                        end
                        2'd1: begin
                            shadow_d[1] = cfg_bit;
                            cnt_d       = 2'd2;
                        end
                        default: begin
                            shadow_d[0] = cfg_bit;
                            cnt_d       = 2'd1;
                        end
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A config-bit cycle blocks operands so every accepted pair sees one stable table.
    assign cfg_busy = (state_q == LOAD);
    assign in_ready = !cfg_busy && !cfg_valid && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid_q && out_ready;

    always_comb begin
        o_d         = o_q;
        out_valid_d = out_valid_q;
        xfer_d      = xfer_q + {15'd0, xfer};
        if (accept) begin
            o_d         = lut_apply(lut_q, a, b);
            out_valid_d = 1'b1;
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shadow_q    <= '0;
            cnt_q       <= '0;
            lut_q       <= DEFAULT_LUT;
            o_q         <= '0;
            out_valid_q <= 1'b0;
            xfer_q      <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            cnt_q       <= cnt_d;
            lut_q       <= lut_d;
            o_q         <= o_d;
            out_valid_q <= out_valid_d;
            xfer_q      <= xfer_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign o          = o_q;
    assign lut        = lut_q;
    assign xfer_count = xfer_q;

endmodule

// File: tb/tb_lut_gate_pipe.sv
// Self-checking bench for lut_gate_pipe: vector table plus queue scoreboard,
// with hand sequences for config loading, backpressure, reset and counter wrap.
module tb_lut_gate_pipe;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_bit;
    logic        cfg_busy;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  o;
    logic [3:0]  lut;
    logic [15:0] xfer_count;

    lut_gate_pipe #(.WIDTH(8), .DEFAULT_LUT(4'b1000)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
        .cfg_busy(cfg_busy), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .o(o),
        .lut(lut), .xfer_count(xfer_count)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] o;
    } vec_t;

    vec_t       vecs[9];
    logic [7:0] exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         xfer_seen = 0;
    int         base = 0;
    int         last_xfer_cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every observed output transfer pops one expected result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra: got o=%0h expected no output", o);
            end else begin
                chk("sb_o", {24'd0, o}, {24'd0, exp_q.pop_front()});
            end
            xfer_seen++;
            last_xfer_cyc = cyc;
        end
    end

    // Called and returns at posedge+1; holds operands until the handshake.
    task automatic send(input logic [7:0] aa, input logic [7:0] bb, input logic [7:0] ex);
        int n;
        n = 0;
        in_valid = 1'b1;
        a = aa;
        b = bb;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("send_accept", {31'd0, in_ready}, 32'd1);
        if (in_ready) exp_q.push_back(ex);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Bit k of tt is table entry k; gap[k] inserts an idle cycle after bit k.
    task automatic cfg_load(input logic [3:0] tt, input logic [3:0] gap);
        for (int k = 0; k < 4; k++) begin
            cfg_valid = 1'b1;
            cfg_bit = tt[k];
            @(negedge clk);
            chk("cfg_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
            cfg_valid = 1'b0;
            chk("cfg_busy", {31'd0, cfg_busy}, (k < 3) ? 32'd1 : 32'd0);
            if (gap[k]) begin
                @(negedge clk);
                chk("gap_busy", {31'd0, cfg_busy}, 32'd1);
                chk("gap_in_ready", {31'd0, in_ready}, 32'd0);
                @(posedge clk);
                #1;
            end
        end
        chk("cfg_lut", {28'd0, lut}, {28'd0, tt});
    endtask

    task automatic drain();
        logic [15:0] ec;
        repeat (3) @(posedge clk);
        #1;
        ec = 16'(xfer_seen - base);
        chk("drain_empty", exp_q.size(), 32'd0);
        chk("xfer_count", {16'd0, xfer_count}, {16'd0, ec});
    endtask

    initial begin
        int rel;
        int n;
        vecs[0] = '{8'hF0, 8'hCC, 8'hC0};
        vecs[1] = '{8'hFF, 8'h00, 8'h00};
        vecs[2] = '{8'hAA, 8'hFF, 8'hAA};
        vecs[3] = '{8'hF0, 8'hCC, 8'h3C};
        vecs[4] = '{8'h55, 8'h0F, 8'h5A};
        vecs[5] = '{8'hFF, 8'h0F, 8'hF0};
        vecs[6] = '{8'h33, 8'h55, 8'hEE};
        vecs[7] = '{8'hF0, 8'h0C, 8'hFC};
        vecs[8] = '{8'h00, 8'h00, 8'h00};

        rst = 1'b1;
        cfg_valid = 1'b0;
        cfg_bit = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_lut", {28'd0, lut}, 32'h8);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_o", {24'd0, o}, 32'd0);
        chk("rst_xfer", {16'd0, xfer_count}, 32'd0);
        chk("rst_busy", {31'd0, cfg_busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Default AND: single result, one-cycle valid pulse
        out_ready = 1'b1;
        send(vecs[0].a, vecs[0].b, vecs[0].o);
        chk("and_valid", {31'd0, out_valid}, 32'd1);
        chk("and_o", {24'd0, o}, 32'hC0);
        @(posedge clk);
        #1;
        chk("and_valid_drop", {31'd0, out_valid}, 32'd0);
        chk("and_xfer", {16'd0, xfer_count}, 32'd1);
        for (int i = 1; i < 3; i++) send(vecs[i].a, vecs[i].b, vecs[i].o);
        drain();

        // XOR, contiguous load
        cfg_load(4'b0110, 4'b0000);
        for (int i = 3; i < 5; i++) send(vecs[i].a, vecs[i].b, vecs[i].o);
        drain();

        // NAND with gaps after bits 0 and 1
        cfg_load(4'b0111, 4'b0011);
        for (int i = 5; i < 7; i++) send(vecs[i].a, vecs[i].b, vecs[i].o);
        drain();

        // Backpressure hold, then a back-to-back stream of 4
        out_ready = 1'b0;
        send(8'h33, 8'h55, 8'hEE);
        in_valid = 1'b1;
        a = 8'hFF;
        b = 8'h0F;
        n = xfer_seen - base;
        repeat (5) begin
            @(negedge clk);
            chk("bp_o", {24'd0, o}, 32'hEE);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_xfer", {16'd0, xfer_count}, {16'd0, 16'(n)});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        rel = cyc;
        for (int k = 0; k < 2; k++) begin
            send(vecs[5].a, vecs[5].b, vecs[5].o);
            send(vecs[6].a, vecs[6].b, vecs[6].o);
        end
        drain();
        chk("stream_cycles", last_xfer_cyc - rel, 32'd4);
        chk("stream_count", xfer_seen - base - n, 32'd5);

        // Reset in the middle of a load, with a result held
        out_ready = 1'b0;
        send(8'h00, 8'h00, 8'hFF);
        cfg_valid = 1'b1;
        cfg_bit = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        chk("mid_busy", {31'd0, cfg_busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        base = xfer_seen;
        chk("mid_rst_lut", {28'd0, lut}, 32'h8);
        chk("mid_rst_busy", {31'd0, cfg_busy}, 32'd0);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_xfer", {16'd0, xfer_count}, 32'd0);
        out_ready = 1'b1;
        cfg_load(4'b1110, 4'b0000);
        for (int i = 7; i < 9; i++) send(vecs[i].a, vecs[i].b, vecs[i].o);
        drain();

        // Counter wrap: stream up to 16'hFFFF, then one more transfer
        n = 65535 - (xfer_seen - base);
        for (int i = 0; i < n; i++) send(8'(i), 8'h00, 8'(i));
        drain();
        chk("wrap_max", {16'd0, xfer_count}, 32'hFFFF);
        send(8'h5A, 8'h00, 8'h5A);
        drain();
        chk("wrap_zero", {16'd0, xfer_count}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
